// File: rtl/wb_arbiter_decoder.sv
// wb_arbiter_decoder
//   Shared-bus Wishbone classic interconnect. MASTERNR masters share one bus
//   to SLAVENR slaves. A registered arbiter (fixed priority or round-robin)
//   picks the bus owner. The owner's address is decoded against per-slave
//   base/mask windows. Unmapped accesses and stalled slaves (watchdog) return
//   a one-cycle bus error to the owner.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   madr_i/mdat_i      flattened master address / write data
//   mwe_i/msel_i       master write enables / byte selects
//   mstb_i/mcyc_i      master strobes / cycle requests
//   mdat_o/mack_o/merr_o  read data, ack, error back to each master
//   sadr_o/sdat_o/swe_o/ssel_o/scyc_o  shared slave-side bus
//   sstb_o             per-slave strobe
//   sdat_i/sack_i      per-slave read data / acknowledge
module wb_arbiter_decoder #(
  parameter int unsigned MASTERNR = 2,
  parameter int unsigned SLAVENR  = 2,
  parameter int unsigned ADRW     = 32,
  parameter int unsigned DATW     = 32,
  parameter logic [SLAVENR*ADRW-1:0] SBASE = {32'h4000_0000, 32'h0000_0000},
  parameter logic [SLAVENR*ADRW-1:0] SMASK = {32'hC000_0000, 32'hE000_0000},
  parameter int unsigned ARBMODE  = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [MASTERNR*ADRW-1:0]   madr_i,
  input  logic [MASTERNR*DATW-1:0]   mdat_i,
  output logic [MASTERNR*DATW-1:0]   mdat_o,
  input  logic [MASTERNR-1:0]        mwe_i,
  input  logic [MASTERNR*DATW/8-1:0] msel_i,
  input  logic [MASTERNR-1:0]        mstb_i,
  input  logic [MASTERNR-1:0]        mcyc_i,
  output logic [MASTERNR-1:0]        mack_o,
  output logic [MASTERNR-1:0]        merr_o,
  output logic [ADRW-1:0]            sadr_o,
  output logic [DATW-1:0]            sdat_o,
  input  logic [SLAVENR*DATW-1:0]    sdat_i,
  output logic                       swe_o,
  output logic [DATW/8-1:0]          ssel_o,
  output logic [SLAVENR-1:0]         sstb_o,
  input  logic [SLAVENR-1:0]         sack_i,
  output logic                       scyc_o
);

  localparam int unsigned SELW = DATW / 8;
  localparam int unsigned LW   = (MASTERNR > 1) ? $clog2(MASTERNR) : 1;

  logic [MASTERNR-1:0] gnt, gnt_nxt;
  logic [LW-1:0]       last, last_nxt;
  logic                bus_free, req_found;

  logic [ADRW-1:0]     adr;
  logic [DATW-1:0]     dat;
  logic [SELW-1:0]     sel;
  logic                we, stb, cyc;

  logic [SLAVENR-1:0]  hit;
  logic                found;
  logic [DATW-1:0]     rdat;
  logic                sack_sel;

  logic                err_q;
  logic [31:0]         wd_cnt;
  logic                wd_active, wd_fire;

  // Arbitration: candidate k is visited in priority order; in round-robin
  // mode the order is rotated to start just after the last winner.
  always_comb begin
    gnt_nxt   = gnt;
    last_nxt  = last;
    req_found = 1'b0;
    bus_free  = ~|(gnt & mcyc_i);
    if (bus_free) begin
      gnt_nxt = '0;
      for (int unsigned k = 0; k < MASTERNR; k++) begin
        for (int unsigned m = 0; m < MASTERNR; m++) begin
          if (!req_found && mcyc_i[m] &&
              m == ((ARBMODE != 0) ? ((32'(last) + 1 + k) % MASTERNR) : k)) begin
            gnt_nxt[m] = 1'b1;
            last_nxt   = LW'(m);
            req_found  = 1'b1;
          end
        end
      end
    end
  end

  // Owner mux; gnt is one-hot or zero, so an OR-mux yields 0 when idle.
  always_comb begin
    adr = '0;
    dat = '0;
    sel = '0;
    we  = 1'b0;
    stb = 1'b0;
    cyc = 1'b0;
    for (int unsigned m = 0; m < MASTERNR; m++) begin
      if (gnt[m]) begin
        adr |= madr_i[m*ADRW +: ADRW];
        dat |= mdat_i[m*DATW +: DATW];
        sel |= msel_i[m*SELW +: SELW];
        we  |= mwe_i[m];
        stb |= mstb_i[m];
        cyc |= mcyc_i[m];
      end
    end
  end

  // Address decode, lowest matching window wins.
  always_comb begin
    hit      = '0;
    found    = 1'b0;
    rdat     = '0;
    sack_sel = 1'b0;
    for (int unsigned i = 0; i < SLAVENR; i++) begin
      if (!found && ((adr & SMASK[i*ADRW +: ADRW]) == SBASE[i*ADRW +: ADRW])) begin
        hit[i]   = 1'b1;
        found    = 1'b1;
        rdat     = sdat_i[i*DATW +: DATW];
        sack_sel = sack_i[i];
      end
    end
  end

  assign wd_active = cyc & stb & found;
  // An ack in the same cycle as the limit suppresses the timeout error.
  assign wd_fire   = (TIMEOUT != 0) && wd_active && !sack_sel &&
                     (wd_cnt == TIMEOUT - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt    <= '0;
      last   <= LW'(MASTERNR - 1);
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      err_q <= (cyc & stb & ~found & ~err_q) | wd_fire;
      if (TIMEOUT == 0 || gnt_nxt != gnt || !wd_active || sack_sel || wd_fire)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign scyc_o = |gnt;
  assign sadr_o = adr;
  assign sdat_o = dat;
  assign swe_o  = we;
  assign ssel_o = sel;
  assign sstb_o = (scyc_o & stb) ? hit : '0;

  always_comb begin
    mdat_o = '0;
    mack_o = '0;
    merr_o = '0;
    for (int unsigned m = 0; m < MASTERNR; m++) begin
      if (gnt[m]) begin
        mdat_o[m*DATW +: DATW] = rdat;
        mack_o[m] = sack_sel & stb & ~err_q;
        merr_o[m] = err_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_decoder.sv
module tb_wb_arbiter_decoder;

  localparam logic [31:0] ROM_D = 32'hC0DE_0000;
  localparam logic [31:0] RAM_D = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] madr = '0;
  logic [63:0] mdat = '0;
  logic [1:0]  mwe = '0;
  logic [7:0]  msel = '0;
  logic [1:0]  mstb = '0;
  logic [1:0]  mcyc = '0;
  logic [63:0] sdat;
  logic [1:0]  sack_man = '0;
  logic        auto_ack = 1'b0;

  logic [63:0] mdat_f, mdat_r;
  logic [1:0]  mack_f, mack_r, merr_f, merr_r;
  logic [31:0] sadr_f, sadr_r, sdat_f, sdat_r;
  logic        swe_f, swe_r, scyc_f, scyc_r;
  logic [3:0]  ssel_f, ssel_r;
  logic [1:0]  sstb_f, sstb_r, sack_f, sack_r;

  int n_tests = 0;
  int n_fail  = 0;

  assign sdat   = {RAM_D, ROM_D};
  assign sack_f = auto_ack ? sstb_f : sack_man;
  assign sack_r = auto_ack ? sstb_r : sack_man;

  always #5 clk = ~clk;

  wb_arbiter_decoder #(.ARBMODE(0), .TIMEOUT(4)) u_fix (
    .clk_i(clk), .rst_i(rst), .madr_i(madr), .mdat_i(mdat), .mdat_o(mdat_f),
    .mwe_i(mwe), .msel_i(msel), .mstb_i(mstb), .mcyc_i(mcyc), .mack_o(mack_f),
    .merr_o(merr_f), .sadr_o(sadr_f), .sdat_o(sdat_f), .sdat_i(sdat),
    .swe_o(swe_f), .ssel_o(ssel_f), .sstb_o(sstb_f), .sack_i(sack_f),
    .scyc_o(scyc_f)
  );

  wb_arbiter_decoder #(.ARBMODE(1), .TIMEOUT(4)) u_rr (
    .clk_i(clk), .rst_i(rst), .madr_i(madr), .mdat_i(mdat), .mdat_o(mdat_r),
    .mwe_i(mwe), .msel_i(msel), .mstb_i(mstb), .mcyc_i(mcyc), .mack_o(mack_r),
    .merr_o(merr_r), .sadr_o(sadr_r), .sdat_o(sdat_r), .sdat_i(sdat),
    .swe_o(swe_r), .ssel_o(ssel_r), .sstb_o(sstb_r), .sack_i(sack_r),
    .scyc_o(scyc_r)
  );

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic [31:0] a);
    mcyc[m] = c;
    mstb[m] = s;
    mwe[m]  = 1'b0;
    madr[m*32 +: 32] = a;
    mdat[m*32 +: 32] = '0;
    msel[m*4 +: 4]   = c ? 4'hF : 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 32'h10);
    cyc_start(); cyc_start(); look();
    n_tests++; if ({mack_f, merr_f} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0000", {mack_f, merr_f}); end
    n_tests++; if (mdat_f !== 64'h0) begin n_fail++; $display("FAIL reset_mdat: got %h expected 0", mdat_f); end
    n_tests++; if ({sstb_f, scyc_f, sstb_r, scyc_r} !== 6'b0) begin n_fail++; $display("FAIL reset_slave_ctl: got %b expected 000000", {sstb_f, scyc_f, sstb_r, scyc_r}); end
    n_tests++; if (sadr_f !== 32'h0) begin n_fail++; $display("FAIL reset_sadr: got %h expected 0", sadr_f); end
    cyc_start(); rst = 1'b0; set_m(0, 1'b0, 1'b0, 32'h0);
    cyc_start();
  endtask

  task automatic test_single_read();
    cyc_start(); set_m(0, 1'b1, 1'b1, 32'h0000_0010); look();
    n_tests++; if (scyc_f !== 1'b0) begin n_fail++; $display("FAIL read_latency: scyc=%b expected 0", scyc_f); end
    cyc_start(); look();
    n_tests++; if ({scyc_f, sstb_f, mack_f} !== 5'b10100) begin n_fail++; $display("FAIL read_strobe1: scyc,sstb,mack=%b expected 10100", {scyc_f, sstb_f, mack_f}); end
    n_tests++; if ({sadr_f, swe_f, ssel_f} !== {32'h10, 1'b0, 4'hF}) begin n_fail++; $display("FAIL read_bus: got %h/%b/%h expected 10/0/f", sadr_f, swe_f, ssel_f); end
    cyc_start(); sack_man = 2'b01; look();
    n_tests++; if ({mack_f, merr_f} !== 4'b0100) begin n_fail++; $display("FAIL read_ack: mack,merr=%b expected 0100", {mack_f, merr_f}); end
    n_tests++; if (mdat_f !== {32'h0, ROM_D}) begin n_fail++; $display("FAIL read_data: got %h expected %h", mdat_f, {32'h0, ROM_D}); end
    cyc_start(); sack_man = 2'b00; set_m(0, 1'b0, 1'b0, 32'h0); look();
    n_tests++; if ({mack_f, sstb_f} !== 4'b0) begin n_fail++; $display("FAIL read_end: mack,sstb=%b expected 0000", {mack_f, sstb_f}); end
    cyc_start(); look();
    n_tests++; if (scyc_f !== 1'b0) begin n_fail++; $display("FAIL read_release: scyc=%b expected 0", scyc_f); end
  endtask

  task automatic test_unmapped();
    cyc_start(); set_m(0, 1'b1, 1'b1, 32'h2000_0000); look();
    cyc_start(); look();
    n_tests++; if ({scyc_f, sstb_f, merr_f} !== 5'b10000) begin n_fail++; $display("FAIL unmap_first: scyc,sstb,merr=%b expected 10000", {scyc_f, sstb_f, merr_f}); end
    cyc_start(); look();
    n_tests++; if ({merr_f, mack_f, sstb_f} !== 6'b010000) begin n_fail++; $display("FAIL unmap_err: merr,mack,sstb=%b expected 010000", {merr_f, mack_f, sstb_f}); end
    cyc_start(); look();
    n_tests++; if (merr_f !== 2'b00) begin n_fail++; $display("FAIL unmap_gap: merr=%b expected 00", merr_f); end
    cyc_start(); look();
    n_tests++; if (merr_f !== 2'b01) begin n_fail++; $display("FAIL unmap_repeat: merr=%b expected 01", merr_f); end
    cyc_start(); set_m(0, 1'b0, 1'b0, 32'h0);
    cyc_start();
  endtask

  task automatic test_watchdog();
    cyc_start(); set_m(0, 1'b1, 1'b1, 32'h4000_0100); look();
    for (int k = 1; k <= 4; k++) begin
      cyc_start(); look();
      n_tests++; if ({sstb_f, mack_f, merr_f} !== 6'b100000) begin n_fail++; $display("FAIL wd_wait%0d: sstb,mack,merr=%b expected 100000", k, {sstb_f, mack_f, merr_f}); end
    end
    cyc_start(); look();
    n_tests++; if ({merr_f, mack_f} !== 4'b0100) begin n_fail++; $display("FAIL wd_timeout: merr,mack=%b expected 0100", {merr_f, mack_f}); end
    cyc_start(); set_m(0, 1'b0, 1'b0, 32'h0); look();
    n_tests++; if (merr_f !== 2'b00) begin n_fail++; $display("FAIL wd_single_pulse: merr=%b expected 00", merr_f); end
    cyc_start();
  endtask

  task automatic test_wd_ack_wins();
    cyc_start(); set_m(0, 1'b1, 1'b1, 32'h4000_0200); look();
    cyc_start(); cyc_start(); cyc_start();
    cyc_start(); sack_man = 2'b10; look();
    n_tests++; if ({mack_f, merr_f} !== 4'b0100) begin n_fail++; $display("FAIL wdack_ack: mack,merr=%b expected 0100", {mack_f, merr_f}); end
    n_tests++; if (mdat_f !== {32'h0, RAM_D}) begin n_fail++; $display("FAIL wdack_data: got %h expected %h", mdat_f, {32'h0, RAM_D}); end
    cyc_start(); sack_man = 2'b00; set_m(0, 1'b0, 1'b0, 32'h0); look();
    n_tests++; if ({mack_f, merr_f} !== 4'b0000) begin n_fail++; $display("FAIL wdack_no_err: mack,merr=%b expected 0000", {mack_f, merr_f}); end
    cyc_start();
  endtask

  task automatic test_fixed_handover();
    cyc_start(); set_m(0, 1'b1, 1'b1, 32'h0000_0010); set_m(1, 1'b1, 1'b1, 32'h4000_0004); look();
    cyc_start(); sack_man = 2'b01; look();
    n_tests++; if ({sstb_f, mack_f} !== 4'b0101 || sadr_f !== 32'h10) begin n_fail++; $display("FAIL fix_m0_first: sstb,mack=%b sadr=%h expected 0101 10", {sstb_f, mack_f}, sadr_f); end
    cyc_start(); sack_man = 2'b00; set_m(0, 1'b0, 1'b0, 32'h0); look();
    n_tests++; if ({scyc_f, sstb_f, mack_f} !== 5'b10000) begin n_fail++; $display("FAIL fix_release: scyc,sstb,mack=%b expected 10000", {scyc_f, sstb_f, mack_f}); end
    cyc_start(); look();
    n_tests++; if ({scyc_f, sstb_f} !== 3'b110 || sadr_f !== 32'h4000_0004) begin n_fail++; $display("FAIL fix_handover: scyc,sstb=%b sadr=%h expected 110 40000004", {scyc_f, sstb_f}, sadr_f); end
    cyc_start(); sack_man = 2'b10; look();
    n_tests++; if (mack_f !== 2'b10) begin n_fail++; $display("FAIL fix_m1_ack: mack=%b expected 10", mack_f); end
    cyc_start(); sack_man = 2'b00; set_m(1, 1'b0, 1'b0, 32'h0);
    cyc_start();
  endtask

  task automatic test_round_robin();
    cyc_start(); rst = 1'b1;
    cyc_start(); rst = 1'b0; auto_ack = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cyc_start(); set_m(0, 1'b1, 1'b1, 32'h0000_0010); set_m(1, 1'b1, 1'b1, 32'h4000_0000); look();
      cyc_start(); look();
      n_tests++; if (mack_f !== 2'b01) begin n_fail++; $display("FAIL fixed_starve%0d: mack=%b expected 01", p, mack_f); end
      n_tests++; if (mack_r !== ((p % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_alternate%0d: mack=%b expected %b", p, mack_r, (p % 2 == 0) ? 2'b01 : 2'b10); end
      cyc_start(); set_m(0, 1'b0, 1'b0, 32'h0); set_m(1, 1'b0, 1'b0, 32'h0);
    end
    auto_ack = 1'b0;
    cyc_start();
  endtask

  task automatic test_reset_mid();
    cyc_start(); set_m(1, 1'b1, 1'b1, 32'h4000_0008); look();
    cyc_start(); look();
    n_tests++; if (sstb_f !== 2'b10) begin n_fail++; $display("FAIL rstmid_owner: sstb=%b expected 10", sstb_f); end
    cyc_start(); rst = 1'b1;
    cyc_start(); rst = 1'b0; set_m(1, 1'b0, 1'b0, 32'h0); sack_man = 2'b10; look();
    n_tests++; if ({scyc_f, sstb_f, mack_f, merr_f, scyc_r} !== 8'b0) begin n_fail++; $display("FAIL rstmid_abort: scyc,sstb,mack,merr,scyc_rr=%b expected 00000000", {scyc_f, sstb_f, mack_f, merr_f, scyc_r}); end
    cyc_start(); sack_man = 2'b00; set_m(0, 1'b1, 1'b1, 32'h0000_0010); set_m(1, 1'b1, 1'b1, 32'h4000_0000); look();
    cyc_start(); look();
    n_tests++; if ({sstb_r, sstb_f} !== 4'b0101 || sadr_r !== 32'h10) begin n_fail++; $display("FAIL rstmid_m0_first: sstb_rr,sstb_fix=%b sadr_rr=%h expected 0101 10", {sstb_r, sstb_f}, sadr_r); end
    cyc_start(); set_m(0, 1'b0, 1'b0, 32'h0); set_m(1, 1'b0, 1'b0, 32'h0);
    cyc_start();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_unmapped();
    test_watchdog();
    test_wd_ack_wins();
    test_fixed_handover();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
